y86_mem_arbiter: RTL and testbench

- Sequencer and arbiter for the single-ported 64-bit word data memory of the Y86 pipeline.
- Shares the memory between two requesters: the fetch stage (read-only) and the memory stage (read/write for rmmovq/mrmovq/pushq/popq/call/ret).
- Owns the memory-array control signals; the pipeline stalls on the missing grant/response.
- Flags out-of-range or misaligned addresses with status ADR instead of accessing memory.

---
 rtl/y86_mem_pkg.sv | 23 ++
 rtl/y86_starve_ctr.sv | 32 +++
 rtl/y86_mem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_y86_mem_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_mem_pkg.sv
// Shared types and constants for the Y86 data-memory arbiter.
// Address status helper classifies a byte address as AOK or ADR for a given word-address width.
package y86_mem_pkg;

  localparam int unsigned WORD_BYTES = 8;
  localparam int unsigned WORD_SHIFT = $clog2(WORD_BYTES);

  typedef logic [1:0] stat_t;
  localparam stat_t STAT_AOK = 2'd1;
  localparam stat_t STAT_ADR = 2'd3;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} arb_state_e;
  typedef enum logic {OWN_IF, OWN_DM} owner_e;

  // ADR when the byte address is not word aligned or lies beyond 2**aw words.
  function automatic stat_t addr_stat(input logic [63:0] addr, input int unsigned aw);
    logic [63:0] w_hi;
    w_hi = addr >> (aw + WORD_SHIFT);
    if ((addr[WORD_SHIFT-1:0] != '0) || (w_hi != '0)) return STAT_ADR;
    return STAT_AOK;
  endfunction

endpackage

// File: rtl/y86_starve_ctr.sv
// Saturating count of consecutive arbitrations fetch has lost to the memory stage.
// o_sat tells the arbiter to hand the next IDLE grant to fetch.
module y86_starve_ctr
  import y86_mem_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  localparam int unsigned CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_MAX);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_sat = (r_cnt == CNT_MAX);

endmodule

// File: rtl/y86_mem_arbiter.sv
// Sequencer/arbiter sharing the single-ported 64-bit data memory between fetch and memory stage.
// Optional fetch starvation guard enabled by defining Y86_ARB_STARVE_GUARD_EN.
module y86_mem_arbiter
  import y86_mem_pkg::*;
#(
  parameter int unsigned AW       = 10,
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned WAIT_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [63:0]   if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [63:0]   if_rdata,
  output logic          if_err,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [63:0]   dm_addr,
  input  logic [63:0]   dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [63:0]   dm_rdata,
  output logic          dm_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [63:0]   mem_wdata,
  input  logic [63:0]   mem_rdata
);

  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT);

  if ((MEM_LAT == 0) || (MEM_LAT > 7)) begin : g_lat_chk
    $error("MEM_LAT must be in 1..7");
  end
  if (WAIT_MAX == 0) begin : g_wait_chk
    $error("WAIT_MAX must be at least 1");
  end

  arb_state_e    r_state, w_state_nxt;
  owner_e        r_owner;
  logic          r_we;
  logic [2:0]    r_lat_cnt;
  logic          r_if_rvalid, r_if_err, r_dm_rvalid, r_dm_err;
  logic [63:0]   r_if_rdata, r_dm_rdata;
  logic          r_mem_en, r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [63:0]   r_mem_wdata;

  logic          w_idle, w_if_win, w_dm_win, w_any_win, w_force_if, w_addr_err;
  logic [63:0]   w_sel_addr;

  assign w_idle = (r_state == IDLE);

`ifdef Y86_ARB_STARVE_GUARD_EN
  logic w_starve_inc, w_starve_clr;

  assign w_starve_inc = w_idle && if_req && w_dm_win;
  assign w_starve_clr = w_if_win || !if_req;

  y86_starve_ctr #(
    .WAIT_MAX(WAIT_MAX)
  ) u_starve_ctr (
    .clk  (clk),
    .rst_n(rst_n),
    .i_inc(w_starve_inc),
    .i_clr(w_starve_clr),
    .o_sat(w_force_if)
  );
`else
  assign w_force_if = 1'b0;
`endif

  // Memory stage holds the older instruction, so it wins ties unless fetch is starved.
  assign w_if_win   = w_idle && if_req && (!dm_req || w_force_if);
  assign w_dm_win   = w_idle && dm_req && !w_if_win;
  assign w_any_win  = w_if_win || w_dm_win;
  assign if_gnt     = w_if_win;
  assign dm_gnt     = w_dm_win;
  assign w_sel_addr = w_dm_win ? dm_addr : if_addr;
  assign w_addr_err = (addr_stat(w_sel_addr, AW) == STAT_ADR);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_any_win) w_state_nxt = w_addr_err ? RESP : ACCESS;
      ACCESS:  w_state_nxt = WAIT;
      WAIT:    if (r_lat_cnt == LAT_LAST) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner     <= OWN_IF;
      r_we        <= 1'b0;
      r_lat_cnt   <= '0;
      r_if_rvalid <= 1'b0;
      r_if_err    <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rvalid <= 1'b0;
      r_dm_err    <= 1'b0;
      r_dm_rdata  <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_win) begin
            r_owner <= w_dm_win ? OWN_DM : OWN_IF;
            r_we    <= w_dm_win && dm_we;
            if (w_addr_err) begin
              // Bad address: answer straight away without touching the array.
              if (w_dm_win) begin
                r_dm_rvalid <= 1'b1;
                r_dm_err    <= 1'b1;
                r_dm_rdata  <= '0;
              end else begin
                r_if_rvalid <= 1'b1;
                r_if_err    <= 1'b1;
                r_if_rdata  <= '0;
              end
            end else begin
              r_mem_en    <= 1'b1;
              r_mem_we    <= w_dm_win && dm_we;
              r_mem_addr  <= w_sel_addr[AW+WORD_SHIFT-1:WORD_SHIFT];
              r_mem_wdata <= w_dm_win ? dm_wdata : '0;
            end
          end
        end
        ACCESS: r_lat_cnt <= 3'd1;
        WAIT: begin
          if (r_lat_cnt == LAT_LAST) begin
            if (r_owner == OWN_DM) begin
              r_dm_rvalid <= 1'b1;
              r_dm_err    <= 1'b0;
              r_dm_rdata  <= r_we ? '0 : mem_rdata;
            end else begin
              r_if_rvalid <= 1'b1;
              r_if_err    <= 1'b0;
              r_if_rdata  <= mem_rdata;
            end
          end else begin
            r_lat_cnt <= r_lat_cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign if_rvalid = r_if_rvalid;
  assign if_err    = r_if_err;
  assign if_rdata  = r_if_rdata;
  assign dm_rvalid = r_dm_rvalid;
  assign dm_err    = r_dm_err;
  assign dm_rdata  = r_dm_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_y86_mem_arbiter.sv
// Bench for y86_mem_arbiter: directed scenarios plus random traffic against a
// transaction-level timing/memory model checked every cycle.
module tb_y86_mem_arbiter;

  localparam int unsigned AW       = 10;
  localparam int unsigned MEM_LAT  = 1;
  localparam int unsigned WAIT_MAX = 4;
  localparam int          NCYC     = 8000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [63:0]   if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic          if_gnt, if_rvalid, if_err, dm_gnt, dm_rvalid, dm_err;
  logic [63:0]   if_rdata, dm_rdata, mem_wdata, mem_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  y86_mem_arbiter #(
    .AW(AW), .MEM_LAT(MEM_LAT), .WAIT_MAX(WAIT_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Memory array driven by the DUT; garbage on mem_rdata whenever no read is due.
  logic [63:0] tb_ram  [2**AW];
  logic [63:0] ref_mem [2**AW];
  logic [63:0] rd_pipe [MEM_LAT];
  assign mem_rdata = rd_pipe[MEM_LAT-1];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tb_ram[mem_addr] <= mem_wdata;
      rd_pipe[0] <= tb_ram[mem_addr];
    end else begin
      rd_pipe[0] <= {$urandom, $urandom};
    end
    for (int k = 1; k < MEM_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, required %h", nm, cyc, act, exp);
    end
  endtask

  // Expected-event schedule indexed by cycle number.
  bit            s_mem_en [NCYC];
  bit            s_mem_we [NCYC];
  logic [AW-1:0] s_mem_addr [NCYC];
  logic [63:0]   s_mem_wdata [NCYC];
  bit            s_if_rv [NCYC];
  bit            s_dm_rv [NCYC];
  bit            s_err [NCYC];
  logic [63:0]   s_rdata [NCYC];
  int            next_free = 0;
  int            starve = 0;
  logic [63:0]   h_if = '0, h_dm = '0;

  task automatic model_step();
    bit          eg_if, eg_dm, force_if, er;
    logic [63:0] a, rd;
    int          w, tr;
    eg_if = 0;
    eg_dm = 0;
    if (cyc > NCYC - 16) return;
    if (!rst_n) begin
      for (int k = cyc; k < NCYC; k++) begin
        s_mem_en[k] = 0; s_if_rv[k] = 0; s_dm_rv[k] = 0;
      end
      next_free = 0; starve = 0; h_if = '0; h_dm = '0;
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_if_rvalid", if_rvalid, 0);
      chk("rst_dm_rvalid", dm_rvalid, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_dm_rdata", dm_rdata, 0);
      chk("rst_mem_addr", 64'(mem_addr), 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      return;
    end
`ifdef Y86_ARB_STARVE_GUARD_EN
    force_if = (starve == WAIT_MAX);
`else
    force_if = 0;
`endif
    if (cyc >= next_free) begin
      if (if_req && (!dm_req || force_if)) eg_if = 1;
      else if (dm_req)                     eg_dm = 1;
    end
    if (!if_req || eg_if)                       starve = 0;
    else if (eg_dm && (starve < int'(WAIT_MAX))) starve++;
    if (eg_if || eg_dm) begin
      a  = eg_dm ? dm_addr : if_addr;
      er = ((a % 8) != 0) || (a >= 64'(2**AW) * 8);
      if (er) begin
        tr = cyc + 1;
        rd = '0;
        next_free = cyc + 2;
      end else begin
        w = int'(a / 8);
        s_mem_en[cyc+1]    = 1;
        s_mem_addr[cyc+1]  = AW'(w);
        s_mem_we[cyc+1]    = eg_dm && dm_we;
        s_mem_wdata[cyc+1] = dm_wdata;
        if (eg_dm && dm_we) begin
          ref_mem[w] = dm_wdata;
          rd = '0;
        end else begin
          rd = ref_mem[w];
        end
        tr = cyc + 2 + MEM_LAT;
        next_free = cyc + 3 + MEM_LAT;
      end
      if (eg_dm) s_dm_rv[tr] = 1;
      else       s_if_rv[tr] = 1;
      s_err[tr]   = er;
      s_rdata[tr] = rd;
    end
    chk("if_gnt", if_gnt, eg_if);
    chk("dm_gnt", dm_gnt, eg_dm);
    chk("mem_en", mem_en, s_mem_en[cyc]);
    chk("mem_we", mem_we, s_mem_en[cyc] && s_mem_we[cyc]);
    if (s_mem_en[cyc]) begin
      chk("mem_addr", 64'(mem_addr), 64'(s_mem_addr[cyc]));
      if (s_mem_we[cyc]) chk("mem_wdata", mem_wdata, s_mem_wdata[cyc]);
    end
    chk("if_rvalid", if_rvalid, s_if_rv[cyc]);
    chk("dm_rvalid", dm_rvalid, s_dm_rv[cyc]);
    if (s_if_rv[cyc]) begin
      h_if = s_rdata[cyc];
      chk("if_err", if_err, s_err[cyc]);
    end
    if (s_dm_rv[cyc]) begin
      h_dm = s_rdata[cyc];
      chk("dm_err", dm_err, s_err[cyc]);
    end
    chk("if_rdata", if_rdata, h_if);
    chk("dm_rdata", dm_rdata, h_dm);
  endtask

  initial forever begin
    @(negedge clk);
    model_step();
  end

  // One request through to its response; lat counts cycles from grant to rvalid.
  task automatic txn(input bit dm, input bit we, input logic [63:0] addr, input logic [63:0] wd,
                     output logic [63:0] rd, output bit err, output int lat, output bit en1,
                     output logic [AW-1:0] a1);
    int k;
    @(posedge clk); #1;
    if (dm) begin
      dm_req = 1; dm_we = we; dm_addr = addr; dm_wdata = wd;
    end else begin
      if_req = 1; if_addr = addr;
    end
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(dm ? dm_gnt : if_gnt) && (k < 40));
    if (!(dm ? dm_gnt : if_gnt)) chk("gnt_timeout", 0, 1);
    @(posedge clk); #1;
    if (dm) begin
      dm_req = 0; dm_addr = {$urandom, $urandom}; dm_wdata = {$urandom, $urandom};
    end else begin
      if_req = 0; if_addr = {$urandom, $urandom};
    end
    lat = 0; en1 = 0; a1 = '0;
    do begin
      if (lat > 0) @(negedge clk);
      else         @(negedge clk);
      lat++;
      if (lat == 1) begin
        en1 = mem_en;
        a1  = mem_addr;
      end
    end while (!(dm ? dm_rvalid : if_rvalid) && (lat < 40));
    if (!(dm ? dm_rvalid : if_rvalid)) chk("rvalid_timeout", 0, 1);
    rd  = dm ? dm_rdata : if_rdata;
    err = dm ? dm_err : if_err;
  endtask

  task automatic reset_at(input int phase);
    int k, stale;
    @(posedge clk); #1;
    if_req = 1; if_addr = 64'h30;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!if_gnt && (k < 40));
    if (!if_gnt) chk("rst_gnt_timeout", 0, 1);
    for (int p = 0; p < phase; p++) begin
      @(posedge clk); #1;
      if_req = 0;
    end
    if (phase == 1) chk("pre_rst_mem_en", mem_en, 1);
    if (phase == 3) chk("pre_rst_if_rvalid", if_rvalid, 1);
    rst_n = 0;
    #1;
    chk("async_mem_en", mem_en, 0);
    chk("async_if_rvalid", if_rvalid, 0);
    chk("async_dm_rvalid", dm_rvalid, 0);
    @(posedge clk); #1;
    rst_n = 1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (if_rvalid || dm_rvalid || mem_en) stale++;
    end
    chk("stale_after_reset", stale, 0);
  endtask

  function automatic logic [63:0] rand_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 64'($urandom_range(0, 31) * 8 + $urandom_range(1, 7));
    if (r == 1) return 64'h2000 + 64'($urandom_range(0, 255) * 8);
    if (r == 2) return {$urandom, $urandom} | 64'h8000_0000_0000_0000;
    if (r == 3) return 64'($urandom_range(0, 1023) * 8);
    return 64'($urandom_range(0, 31) * 8);
  endfunction

  task automatic rand_phase(input int n);
    bit g_if, g_dm;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      g_if = if_gnt;
      g_dm = dm_gnt;
      @(posedge clk); #1;
      if (g_if) if_req = 0;
      if (g_dm) dm_req = 0;
      if (if_req && ($urandom_range(0, 19) == 0)) if_req = 0;
      if (dm_req && ($urandom_range(0, 19) == 0)) dm_req = 0;
      if (!if_req) begin
        if_addr = rand_addr();
        if ($urandom_range(0, 2) == 0) if_req = 1;
      end
      if (!dm_req) begin
        dm_addr  = rand_addr();
        dm_we    = 1'($urandom_range(0, 1));
        dm_wdata = {$urandom, $urandom};
        if ($urandom_range(0, 2) == 0) dm_req = 1;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]   rd;
    bit            err, en1;
    int            lat, k, n_dm;
    logic [AW-1:0] a1;
    bit            seen_if;

    for (int i = 0; i < 2**AW; i++) begin
      tb_ram[i]  = {32'hA5A5_0000 | 32'(i), 32'(i) * 32'h0101_0101};
      ref_mem[i] = tb_ram[i];
    end
    tb_ram[5]  = 64'h1122_3344_5566_7788;
    ref_mem[5] = 64'h1122_3344_5566_7788;

    #1 rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_if_rvalid", if_rvalid, 0);
    chk("reset_mem_en", mem_en, 0);
    chk("reset_mem_addr", 64'(mem_addr), 0);
    rst_n = 1;
    repeat (2) @(posedge clk);

    // Fetch read of word 5.
    txn(0, 0, 64'h28, '0, rd, err, lat, en1, a1);
    chk("fetch_latency", lat, 3);
    chk("fetch_mem_en_t1", en1, 1);
    chk("fetch_mem_addr_t1", 64'(a1), 5);
    chk("fetch_rdata", rd, 64'h1122_3344_5566_7788);
    chk("fetch_err", err, 0);

    // Data write then read back.
    txn(1, 1, 64'h40, 64'hDEAD_BEEF, rd, err, lat, en1, a1);
    chk("write_ack_latency", lat, 3);
    chk("write_ack_rdata", rd, 0);
    chk("write_ack_err", err, 0);
    chk("write_mem_addr", 64'(a1), 8);
    txn(1, 0, 64'h40, '0, rd, err, lat, en1, a1);
    chk("readback_rdata", rd, 64'hDEAD_BEEF);

    // Address errors.
    txn(1, 0, 64'h2001, '0, rd, err, lat, en1, a1);
    chk("dm_adr_latency", lat, 1);
    chk("dm_adr_err", err, 1);
    chk("dm_adr_rdata", rd, 0);
    chk("dm_adr_no_mem_en", en1, 0);
    txn(0, 0, 64'h2000, '0, rd, err, lat, en1, a1);
    chk("if_adr_latency", lat, 1);
    chk("if_adr_err", err, 1);
    chk("if_adr_rdata", rd, 0);
    chk("if_adr_no_mem_en", en1, 0);

    // Simultaneous requests: dm first, fetch at the next IDLE cycle.
    @(posedge clk); #1;
    if_req = 1; if_addr = 64'h48; dm_req = 1; dm_we = 0; dm_addr = 64'h50;
    @(negedge clk);
    chk("tie_dm_gnt", dm_gnt, 1);
    chk("tie_if_gnt", if_gnt, 0);
    @(posedge clk); #1;
    dm_req = 0;
    k = 1;
    do begin
      @(negedge clk);
      k++;
    end while (!if_gnt && (k < 40));
    chk("tie_if_gnt_cycle", k, 4 + MEM_LAT);
    @(posedge clk); #1;
    if_req = 0;
    repeat (6) @(posedge clk);

    // Memory stage holding its request continuously.
    #1;
    dm_req = 1; dm_we = 0; dm_addr = 64'h58; if_req = 1; if_addr = 64'h60;
    n_dm = 0; seen_if = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (dm_gnt) n_dm++;
      if (if_gnt) begin
        seen_if = 1;
        break;
      end
    end
`ifdef Y86_ARB_STARVE_GUARD_EN
    chk("starve_if_gnt_seen", seen_if, 1);
    chk("starve_dm_grants_before_if", n_dm, WAIT_MAX);
    @(posedge clk); #1;
    if_req = 0; dm_req = 0;
`else
    chk("strict_no_if_gnt", seen_if, 0);
    chk("strict_dm_grants", n_dm, 15);
    @(posedge clk); #1;
    dm_req = 0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!if_gnt && (k < 40));
    chk("strict_if_gnt_after_dm_drop", if_gnt, 1);
    @(posedge clk); #1;
    if_req = 0;
`endif
    repeat (8) @(posedge clk);

    // Reset during ACCESS, WAIT and RESP; each followed by a clean transaction.
    for (int ph = 1; ph <= 3; ph++) begin
      reset_at(ph);
      txn(0, 0, 64'h28, '0, rd, err, lat, en1, a1);
      chk("post_reset_latency", lat, 3);
      chk("post_reset_rdata", rd, 64'h1122_3344_5566_7788);
    end

    rand_phase(1500);
    @(posedge clk); #1;
    if_req = 0; dm_req = 0;
    repeat (12) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
